// File: rtl/linear_layer_fifo_pkg.sv
// Shared helpers for the Linear_Layer SRL FIFO family: width/capacity functions
// and the sticky error-flag record.
package linear_layer_fifo_pkg;

  localparam int FIFO_MIN_DEPTH = 2;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((32'sd1 <<< result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Total entries held: SRL plus the optional prefetch register.
  function automatic int fifo_capacity(input int depth, input int out_reg);
    return depth + ((out_reg != 0) ? 1 : 0);
  endfunction

  function automatic int fifo_cnt_width(input int depth, input int out_reg);
    return clog2(fifo_capacity(depth, out_reg) + 1);
  endfunction

endpackage

// File: rtl/linear_layer_srl_fifo_store.sv
// Reset-less shift-register storage; new data enters at index 0, the read
// address selects any tap combinationally.
module linear_layer_srl_fifo_store
  import linear_layer_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  localparam int ADDR_W    = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  // Shift chain; deliberately no reset so it maps onto SRL primitives.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem_r[i] <= mem_r[i-1];
      end
    end
  end

  // Tap select; out-of-range addresses only occur while the SRL is empty.
  always_comb begin
    if (int'(addr) < DEPTH) begin
      dout = mem_r[addr];
    end else begin
      dout = mem_r[0];
    end
  end

endmodule

// File: rtl/linear_layer_srl_fifo_v2.sv
// SRL-backed stream FIFO with registered handshake/occupancy flags, sticky error
// flags and an optional prefetch register in front of the output.
module linear_layer_srl_fifo_v2
  import linear_layer_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int AF_MARGIN  = 1,
  parameter int AE_MARGIN  = 1,
  parameter int OUT_REG    = 0,
  localparam int CNT_W     = fifo_cnt_width(DEPTH, OUT_REG)
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [DATA_WIDTH-1:0] if_din,
  input  logic                  if_write,
  output logic                  if_full_n,
  output logic                  if_almost_full,
  output logic [DATA_WIDTH-1:0] if_dout,
  input  logic                  if_read,
  output logic                  if_empty_n,
  output logic                  if_almost_empty,
  output logic [CNT_W-1:0]      if_count,
  output logic                  err_overflow,
  output logic                  err_underflow
);

  localparam int CAP       = fifo_capacity(DEPTH, OUT_REG);
  localparam int SRL_CNT_W = clog2(DEPTH + 1);
  localparam int ADDR_W    = clog2(DEPTH);
  localparam logic [CNT_W-1:0] CAP_C = CNT_W'(CAP);
  localparam logic [CNT_W-1:0] AF_C  = CNT_W'(AF_MARGIN);
  localparam logic [CNT_W-1:0] AE_C  = CNT_W'(AE_MARGIN);

  logic [SRL_CNT_W-1:0]  srl_cnt_r, srl_cnt_nxt_s, head_full_s;
  logic [ADDR_W-1:0]     head_addr_s;
  logic [DATA_WIDTH-1:0] srl_dout_s;
  logic                  wr_acc_s, rd_acc_s, srl_pop_s, shift_en_s;
  logic                  pre_valid_r, pre_valid_nxt_s;
  logic [DATA_WIDTH-1:0] pre_data_r, pre_data_nxt_s;
  logic [CNT_W-1:0]      count_r, count_nxt_s;
  logic                  full_n_r, empty_n_r, af_r, ae_r;
  logic                  full_n_nxt_s, empty_n_nxt_s, af_nxt_s, ae_nxt_s;
  fifo_err_t             err_r, err_nxt_s;

  assign wr_acc_s    = if_write & full_n_r;
  assign rd_acc_s    = if_read & empty_n_r;
  assign shift_en_s  = wr_acc_s & ap_rst_n;
  assign head_full_s = srl_cnt_r - SRL_CNT_W'(1);
  assign head_addr_s = head_full_s[ADDR_W-1:0];

  linear_layer_srl_fifo_store #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_store (
    .clk (ap_clk),
    .we  (shift_en_s),
    .addr(head_addr_s),
    .din (if_din),
    .dout(srl_dout_s)
  );

  // Head hand-off: either the reader takes the SRL head directly, or the
  // prefetch register refills whenever it is empty or being drained.
  always_comb begin
    srl_pop_s       = 1'b0;
    pre_valid_nxt_s = pre_valid_r;
    pre_data_nxt_s  = pre_data_r;
    if (OUT_REG != 0) begin
      if ((srl_cnt_r != {SRL_CNT_W{1'b0}}) && (!pre_valid_r || rd_acc_s)) begin
        srl_pop_s       = 1'b1;
        pre_valid_nxt_s = 1'b1;
        pre_data_nxt_s  = srl_dout_s;
      end else if (rd_acc_s) begin
        pre_valid_nxt_s = 1'b0;
      end else begin
        pre_valid_nxt_s = pre_valid_r;
      end
    end else begin
      srl_pop_s       = rd_acc_s;
      pre_valid_nxt_s = 1'b0;
      pre_data_nxt_s  = {DATA_WIDTH{1'b0}};
    end
  end

  // Occupancy and flags are derived from next-state count so they register in step.
  always_comb begin
    srl_cnt_nxt_s = srl_cnt_r + SRL_CNT_W'(wr_acc_s) - SRL_CNT_W'(srl_pop_s);
    count_nxt_s   = CNT_W'(srl_cnt_nxt_s) + CNT_W'(pre_valid_nxt_s);
    full_n_nxt_s  = (count_nxt_s != CAP_C);
    af_nxt_s      = ((CAP_C - count_nxt_s) <= AF_C);
    ae_nxt_s      = (count_nxt_s <= AE_C);
    if (OUT_REG != 0) begin
      empty_n_nxt_s = pre_valid_nxt_s;
    end else begin
      empty_n_nxt_s = (srl_cnt_nxt_s != {SRL_CNT_W{1'b0}});
    end
    err_nxt_s.overflow  = err_r.overflow | (if_write & ~full_n_r);
    err_nxt_s.underflow = err_r.underflow | (if_read & ~empty_n_r);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      srl_cnt_r   <= {SRL_CNT_W{1'b0}};
      pre_valid_r <= 1'b0;
      pre_data_r  <= {DATA_WIDTH{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      full_n_r    <= 1'b0;
      empty_n_r   <= 1'b0;
      af_r        <= 1'b0;
      ae_r        <= 1'b1;
      err_r       <= '{overflow: 1'b0, underflow: 1'b0};
    end else begin
      srl_cnt_r   <= srl_cnt_nxt_s;
      pre_valid_r <= pre_valid_nxt_s;
      pre_data_r  <= pre_data_nxt_s;
      count_r     <= count_nxt_s;
      full_n_r    <= full_n_nxt_s;
      empty_n_r   <= empty_n_nxt_s;
      af_r        <= af_nxt_s;
      ae_r        <= ae_nxt_s;
      err_r       <= err_nxt_s;
    end
  end

  assign if_full_n       = full_n_r;
  assign if_almost_full  = af_r;
  assign if_empty_n      = empty_n_r;
  assign if_almost_empty = ae_r;
  assign if_count        = count_r;
  assign err_overflow    = err_r.overflow;
  assign err_underflow   = err_r.underflow;
  assign if_dout         = (OUT_REG != 0) ? pre_data_r : srl_dout_s;

endmodule

// File: tb/tb_linear_layer_srl_fifo_v2.sv
// Bench: two FIFOs (direct output and prefetch output) share one stimulus stream;
// a queue model predicts every output each cycle, literal checks pin key points.
module tb_linear_layer_srl_fifo_v2;

  localparam int CAP0 = 4;
  localparam int CAP1 = 5;

  logic       ap_clk, ap_rst_n, if_write, if_read;
  logic [7:0] if_din;

  logic       full_n0, af0, empty_n0, ae0, ov0, un0;
  logic [7:0] dout0;
  logic [2:0] count0;
  logic       full_n1, af1, empty_n1, ae1, ov1, un1;
  logic [7:0] dout1;
  logic [2:0] count1;

  int checks = 0;
  int errors = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit m_full_n0, m_empty_n0, m_ov0, m_un0;
  bit m_full_n1, m_empty_n1, m_ov1, m_un1;
  bit live = 1'b0;

  linear_layer_srl_fifo_v2 #(.DATA_WIDTH(8), .DEPTH(4), .AF_MARGIN(1), .AE_MARGIN(1), .OUT_REG(0)) dut0 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .if_din(if_din), .if_write(if_write),
    .if_full_n(full_n0), .if_almost_full(af0), .if_dout(dout0), .if_read(if_read),
    .if_empty_n(empty_n0), .if_almost_empty(ae0), .if_count(count0),
    .err_overflow(ov0), .err_underflow(un0)
  );

  linear_layer_srl_fifo_v2 #(.DATA_WIDTH(8), .DEPTH(4), .AF_MARGIN(1), .AE_MARGIN(1), .OUT_REG(1)) dut1 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .if_din(if_din), .if_write(if_write),
    .if_full_n(full_n1), .if_almost_full(af1), .if_dout(dout1), .if_read(if_read),
    .if_empty_n(empty_n1), .if_almost_empty(ae1), .if_count(count1),
    .err_overflow(ov1), .err_underflow(un1)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Queue model: reads take the oldest entry; the prefetch variant exposes an
  // entry only once it was already held before the current edge.
  task automatic model_edge();
    bit wa, ra;
    int survivors;
    if (!ap_rst_n) begin
      q0.delete(); q1.delete();
      m_full_n0 = 1'b0; m_empty_n0 = 1'b0; m_ov0 = 1'b0; m_un0 = 1'b0;
      m_full_n1 = 1'b0; m_empty_n1 = 1'b0; m_ov1 = 1'b0; m_un1 = 1'b0;
      live = 1'b1;
    end else begin
      wa = if_write && m_full_n0;
      ra = if_read && m_empty_n0;
      if (if_write && !m_full_n0) m_ov0 = 1'b1;
      if (if_read && !m_empty_n0) m_un0 = 1'b1;
      if (ra) void'(q0.pop_front());
      if (wa) q0.push_back(if_din);
      m_full_n0  = (q0.size() < CAP0);
      m_empty_n0 = (q0.size() > 0);

      wa = if_write && m_full_n1;
      ra = if_read && m_empty_n1;
      if (if_write && !m_full_n1) m_ov1 = 1'b1;
      if (if_read && !m_empty_n1) m_un1 = 1'b1;
      if (ra) void'(q1.pop_front());
      survivors = q1.size();
      if (wa) q1.push_back(if_din);
      m_full_n1  = (q1.size() < CAP1);
      m_empty_n1 = (survivors > 0);
    end
  endtask

  task automatic step(input logic w, input logic [7:0] d, input logic r);
    if_write = w;
    if_din   = d;
    if_read  = r;
    @(posedge ap_clk);
    model_edge();
    #1;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge ap_clk);
      if (live) begin
        chk("d0_count",   32'(count0),   32'(q0.size()));
        chk("d0_full_n",  32'(full_n0),  32'(m_full_n0));
        chk("d0_empty_n", 32'(empty_n0), 32'(m_empty_n0));
        chk("d0_af",      32'(af0),      32'((CAP0 - q0.size()) <= 1));
        chk("d0_ae",      32'(ae0),      32'(q0.size() <= 1));
        chk("d0_ovf",     32'(ov0),      32'(m_ov0));
        chk("d0_udf",     32'(un0),      32'(m_un0));
        if (m_empty_n0) chk("d0_dout", 32'(dout0), 32'(q0[0]));
        chk("d1_count",   32'(count1),   32'(q1.size()));
        chk("d1_full_n",  32'(full_n1),  32'(m_full_n1));
        chk("d1_empty_n", 32'(empty_n1), 32'(m_empty_n1));
        chk("d1_af",      32'(af1),      32'((CAP1 - q1.size()) <= 1));
        chk("d1_ae",      32'(ae1),      32'(q1.size() <= 1));
        chk("d1_ovf",     32'(ov1),      32'(m_ov1));
        chk("d1_udf",     32'(un1),      32'(m_un1));
        if (m_empty_n1) chk("d1_dout", 32'(dout1), 32'(q1[0]));
      end
    end
  end

  initial begin
    ap_rst_n = 1'b0; if_write = 1'b0; if_read = 1'b0; if_din = 8'h00;
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("rst_count",   32'(count0),  32'd0);
    chk("rst_full_n",  32'(full_n0), 32'd0);
    chk("rst_empty_n", 32'(empty_n0), 32'd0);
    chk("rst_ae_af",   32'({ae0, af0}), 32'h2);
    ap_rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    chk("rel_full_n", 32'(full_n0), 32'd1);

    step(1'b1, 8'h11, 1'b0);
    chk("lat0_empty_n", 32'(empty_n0), 32'd1);
    chk("lat0_dout",    32'(dout0),    32'h11);
    chk("lat1_empty_n0", 32'(empty_n1), 32'd0);
    step(1'b1, 8'h22, 1'b0);
    chk("lat1_empty_n1", 32'(empty_n1), 32'd1);
    chk("lat1_dout",     32'(dout1),    32'h11);
    step(1'b1, 8'h33, 1'b0);
    step(1'b1, 8'h44, 1'b0);
    chk("fill_count",  32'(count0),  32'd4);
    chk("fill_full_n", 32'(full_n0), 32'd0);
    chk("fill_af",     32'(af0),     32'd1);

    step(1'b1, 8'h55, 1'b1);
    chk("ovf_count", 32'(count0), 32'd3);
    chk("ovf_flag",  32'(ov0),    32'd1);
    chk("ovf_dout",  32'(dout0),  32'h22);
    chk("ovf_d1_count", 32'(count1), 32'd4);
    step(1'b0, 8'h00, 1'b1);
    chk("rd_dout33", 32'(dout0), 32'h33);
    step(1'b0, 8'h00, 1'b1);
    chk("rd_dout44", 32'(dout0), 32'h44);
    step(1'b0, 8'h00, 1'b1);
    chk("drain_empty_n", 32'(empty_n0), 32'd0);

    step(1'b0, 8'h00, 1'b1);
    chk("udf_flag",  32'(un0),    32'd1);
    chk("udf_count", 32'(count0), 32'd0);
    step(1'b1, 8'hAA, 1'b1);
    chk("udf_wr_count", 32'(count0), 32'd1);

    step(1'b1, 8'hBB, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'(8'h60 + i), 1'b1);
    end
    chk("steady_count", 32'(count0), 32'd2);
    chk("steady_dout",  32'(dout0),  32'h68);

    step(1'b1, 8'hCC, 1'b0);
    chk("pre_rst_count", 32'(count0), 32'd3);
    ap_rst_n = 1'b0;
    step(1'b0, 8'h00, 1'b0);
    chk("mid_rst", 32'({count0, empty_n0, full_n0, ov0, un0}), 32'd0);
    ap_rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    chk("mid_rel_full_n", 32'(full_n0), 32'd1);
    step(1'b1, 8'h5A, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("post_rst_d0", 32'(dout0), 32'h5A);
    chk("post_rst_d1", 32'(dout1), 32'h5A);
    step(1'b0, 8'h00, 1'b1);

    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 8'(i), 1'b0);
    end
    chk("d1_full_count", 32'(count1),  32'd5);
    chk("d1_full_n",     32'(full_n1), 32'd0);
    chk("d1_full_af",    32'(af1),     32'd1);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 8'h00, 1'b1);
    end
    step(1'b0, 8'h00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
